vga_scan_ctrl: RTL and testbench

Parametrised VGA scan engine; the successor to the fixed 640x480 timing block in the painter/display subsystem.
- Generates hsync/vsync from a divided pixel tick.
- Generates framebuffer read addresses with a scale factor, and compensates for framebuffer read latency.
- Muxes framebuffer pixels, border colour and blanking onto the RGB outputs.
- Sits between the dual-port block RAM read port and the board VGA pins.

---
 rtl/vga_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: parametrised VGA scan engine.
// A pixel tick is derived from clk by CLK_DIV. Horizontal and vertical
// counters run from that tick. A two-tick pipeline issues framebuffer reads
// with a scale factor, absorbs the read latency, and muxes framebuffer data,
// border colour and blanking onto registered RGB/sync outputs.
// Optional build macro: CURSOR_OVERLAY_EN adds a crosshair cursor overlay.
module vga_scan_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int SCALE_LOG2 = 1,
    parameter int FB_W       = 256,
    parameter int FB_H       = 256,
    parameter int ADDR_W     = 16,
    parameter int PIX_W      = 12,
    parameter int RD_LAT     = 1,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_scan_i,
    input  logic [PIX_W-1:0]    border_rgb_i,
    input  logic [PIX_W-1:0]    fb_data_i,
`ifdef CURSOR_OVERLAY_EN
    input  logic [ADDR_W/2-1:0] cur_x_i,
    input  logic [ADDR_W/2-1:0] cur_y_i,
    input  logic [PIX_W-1:0]    cur_rgb_i,
    input  logic                cur_on_i,
`endif
    output logic [ADDR_W-1:0]   fb_addr_o,
    output logic                fb_rd_o,
    output logic [3:0]          vga_r_o,
    output logic [3:0]          vga_g_o,
    output logic [3:0]          vga_b_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                active_o,
    output logic                frame_start_o
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W          = $clog2(H_TOTAL);
    localparam int V_W          = $clog2(V_TOTAL);
    localparam int DIV_W        = $clog2(CLK_DIV);
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Read data is sampled on the tick after the read strobe, so the read
    // must complete inside one pixel period.
    localparam bit CFG_OK = (CLK_DIV >= 2) && (RD_LAT < CLK_DIV);
    if (!CFG_OK) begin : g_bad_cfg
        $error("vga_scan_ctrl: need CLK_DIV >= 2 and RD_LAT < CLK_DIV");
    end

    // Timing state
    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;
    logic             tick;

    // Stage 0 decode of the current scan position
    logic [H_W-1:0]    fx0;
    logic [V_W-1:0]    fy0;
    logic              vis0, in_fb0, hs0, vs0, fs0, hit0;
    logic [ADDR_W-1:0] addr0;

    // Stage 1 pipeline (travels with the outstanding read)
    logic             vis_q, in_fb_q, hs_q, vs_q, fs_q, hit_q;
    logic [PIX_W-1:0] cur_rgb_q;

    // Output registers
    logic [ADDR_W-1:0] fb_addr_q;
    logic              fb_rd_q;
    logic [PIX_W-1:0]  rgb_q, pix_sel;
    logic              hsync_q, vsync_q, active_q, frame_start_q;

    assign tick = en_scan_i && (div_q == DIV_LAST);

    // Next-state for the tick divider and raster counters.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (!en_scan_i) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
            end else begin
                h_d = h_q + H_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Register the divider and raster counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge value of its inputs.
        if (!rst_ni) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Classify the current position and form the scaled framebuffer address.
    always_comb begin
        fx0    = h_q >> SCALE_LOG2;
        fy0    = v_q >> SCALE_LOG2;
        vis0   = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
        in_fb0 = vis0 && (32'(fx0) < FB_W) && (32'(fy0) < FB_H);
        hs0    = (32'(h_q) >= H_SYNC_START) && (32'(h_q) < H_SYNC_END);
        vs0    = (32'(v_q) >= V_SYNC_START) && (32'(v_q) < V_SYNC_END);
        fs0    = (h_q == '0) && (v_q == '0);
        addr0  = ADDR_W'(32'(fy0) * 32'(FB_W) + 32'(fx0));
`ifdef CURSOR_OVERLAY_EN
        hit0   = cur_on_i && in_fb0 &&
                 ((32'(fx0) == 32'(cur_x_i)) || (32'(fy0) == 32'(cur_y_i)));
`else
        hit0   = 1'b0;
`endif
    end

    // Issue the framebuffer read and carry the pixel's attributes alongside it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fb_addr_q <= '0;
            fb_rd_q   <= 1'b0;
            vis_q     <= 1'b0;
            in_fb_q   <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
            hit_q     <= 1'b0;
            cur_rgb_q <= '0;
        end else if (!en_scan_i) begin
            fb_addr_q <= '0;
            fb_rd_q   <= 1'b0;
            vis_q     <= 1'b0;
            in_fb_q   <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
            hit_q     <= 1'b0;
            cur_rgb_q <= '0;
        end else if (tick) begin
            fb_rd_q <= in_fb0;
            if (in_fb0) begin
                fb_addr_q <= addr0;
            end
            vis_q   <= vis0;
            in_fb_q <= in_fb0;
            hs_q    <= hs0;
            vs_q    <= vs0;
            fs_q    <= fs0;
            hit_q   <= hit0;
`ifdef CURSOR_OVERLAY_EN
            cur_rgb_q <= cur_rgb_i;
`else
            cur_rgb_q <= '0;
`endif
        end else begin
            fb_rd_q <= 1'b0;
        end
    end

    // Pick the colour for the pixel whose read has just completed.
    always_comb begin
        pix_sel = '0;
        if (vis_q) begin
            if (!in_fb_q) begin
                pix_sel = border_rgb_i;
            end else if (hit_q) begin
                pix_sel = cur_rgb_q;
            end else begin
                pix_sel = fb_data_i;
            end
        end
    end

    // Load the output registers once per tick; idle while scanning is off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (!en_scan_i) begin
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (tick) begin
                rgb_q         <= pix_sel;
                hsync_q       <= hs_q ? SYNC_POL : ~SYNC_POL;
                vsync_q       <= vs_q ? SYNC_POL : ~SYNC_POL;
                active_q      <= vis_q;
                frame_start_q <= fs_q;
            end
        end
    end

    assign fb_addr_o     = fb_addr_q;
    assign fb_rd_o       = fb_rd_q;
    assign vga_r_o       = rgb_q[PIX_W-1 -: 4];
    assign vga_g_o       = rgb_q[PIX_W-5 -: 4];
    assign vga_b_o       = rgb_q[PIX_W-9 -: 4];
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Testbench for vga_scan_ctrl using reduced timing so whole frames fit.
// Stimulus pushes expected output pixels and framebuffer fetches into
// queues. Monitors compare these against the DUT on the falling clock edge.
module tb_vga_scan_ctrl;

    localparam int H_ACTIVE   = 48;
    localparam int H_FP       = 4;
    localparam int H_SYNC     = 8;
    localparam int H_BP       = 4;
    localparam int V_ACTIVE   = 30;
    localparam int V_FP       = 2;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 2;
    localparam int CLK_DIV    = 4;
    localparam int SCALE_LOG2 = 1;
    localparam int FB_W       = 20;
    localparam int FB_H       = 12;
    localparam int ADDR_W     = 16;
    localparam int PIX_W      = 12;
    localparam int RD_LAT     = 1;
    localparam bit SYNC_POL   = 1'b0;

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int FB_WORDS  = FB_W * FB_H;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                en_scan_i;
    logic [PIX_W-1:0]    border_rgb_i;
    logic [PIX_W-1:0]    fb_data_i = '0;
    logic [ADDR_W/2-1:0] cur_x_i = '0;
    logic [ADDR_W/2-1:0] cur_y_i = '0;
    logic [PIX_W-1:0]    cur_rgb_i = '0;
    logic                cur_on_i = 1'b0;
    logic [ADDR_W-1:0]   fb_addr_o;
    logic                fb_rd_o;
    logic [3:0]          vga_r_o, vga_g_o, vga_b_o;
    logic                hsync_o, vsync_o, active_o, frame_start_o;

    vga_scan_ctrl #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .SCALE_LOG2(SCALE_LOG2), .FB_W(FB_W), .FB_H(FB_H),
        .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT), .SYNC_POL(SYNC_POL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_scan_i     (en_scan_i),
        .border_rgb_i  (border_rgb_i),
        .fb_data_i     (fb_data_i),
`ifdef CURSOR_OVERLAY_EN
        .cur_x_i       (cur_x_i),
        .cur_y_i       (cur_y_i),
        .cur_rgb_i     (cur_rgb_i),
        .cur_on_i      (cur_on_i),
`endif
        .fb_addr_o     (fb_addr_o),
        .fb_rd_o       (fb_rd_o),
        .vga_r_o       (vga_r_o),
        .vga_g_o       (vga_g_o),
        .vga_b_o       (vga_b_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .active_o      (active_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk = ~clk;

    // Free-running cycle count: after posedge N it reads N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer contents and a single-cycle-latency read port.
    logic [PIX_W-1:0] mem [FB_WORDS];
    always @(posedge clk) begin
        if (fb_rd_o) begin
            fb_data_i <= (int'(fb_addr_o) < FB_WORDS) ? mem[fb_addr_o] : 12'hEEE;
        end
    end

    typedef struct {
        int               due;
        bit               idle_bus;
        bit               act;
        logic [PIX_W-1:0] rgb;
        bit               hs;
        bit               vs;
        bit               fs;
    } exp_t;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
    } fetch_t;

    exp_t   sb_q[$];
    fetch_t fq[$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic exp_t idle_rec(int due, bit bus);
        exp_t e;
        e.due      = due;
        e.idle_bus = bus;
        e.act      = 1'b0;
        e.rgb      = '0;
        e.hs       = !SYNC_POL;
        e.vs       = !SYNC_POL;
        e.fs       = 1'b0;
        return e;
    endfunction

    // Reference: the p-th raster position after the scan (re)starts at (0,0).
    function automatic exp_t pix_rec(int p, int due);
        exp_t e;
        int   h, v, fx, fy;
        bit   vis, in_fb, hit;
        h     = p % H_TOTAL;
        v     = (p / H_TOTAL) % V_TOTAL;
        fx    = h >> SCALE_LOG2;
        fy    = v >> SCALE_LOG2;
        vis   = (h < H_ACTIVE) && (v < V_ACTIVE);
        in_fb = vis && (fx < FB_W) && (fy < FB_H);
`ifdef CURSOR_OVERLAY_EN
        hit   = cur_on_i && in_fb && (fx == int'(cur_x_i) || fy == int'(cur_y_i));
`else
        hit   = 1'b0;
`endif
        e.due      = due;
        e.idle_bus = 1'b0;
        e.act      = vis;
        e.rgb      = !vis ? '0 : !in_fb ? border_rgb_i : hit ? cur_rgb_i : mem[fy * FB_W + fx];
        e.hs       = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
        e.vs       = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
        e.fs       = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic bit pix_in_fb(int p, output logic [ADDR_W-1:0] addr);
        int h, v, fx, fy;
        h    = p % H_TOTAL;
        v    = (p / H_TOTAL) % V_TOTAL;
        fx   = h >> SCALE_LOG2;
        fy   = v >> SCALE_LOG2;
        addr = ADDR_W'(fy * FB_W + fx);
        return (h < H_ACTIVE) && (v < V_ACTIVE) && (fx < FB_W) && (fy < FB_H);
    endfunction

    // Run one scan segment of len clocks, starting from posedge+1 with
    // en_scan rising (or reset releasing with en_scan held high). The
    // segment ends with en_scan dropping or reset asserting.
    task automatic scan(input int len, input bit end_rst);
        int                c0;
        logic [ADDR_W-1:0] a;
        c0 = cyc;
        rst_ni    = 1'b1;
        en_scan_i = 1'b1;
        for (int k = 0; CLK_DIV * (k + 1) <= len; k++) begin
            if (k == 0) sb_q.push_back(idle_rec(c0 + CLK_DIV, 1'b0));
            else        sb_q.push_back(pix_rec(k - 1, c0 + CLK_DIV * (k + 1)));
        end
        for (int p = 0; CLK_DIV * (p + 1) <= len; p++) begin
            if (end_rst && CLK_DIV * (p + 1) == len) break;
            if (pix_in_fb(p, a)) fq.push_back('{due: c0 + CLK_DIV * (p + 1), addr: a});
        end
        repeat (len) @(posedge clk);
        #1;
        if (end_rst) begin
            rst_ni = 1'b0;
            sb_q.push_back(idle_rec(cyc, 1'b1));
            repeat (3) @(posedge clk);
            #1;
        end else begin
            en_scan_i = 1'b0;
            sb_q.push_back(idle_rec(cyc + 1, 1'b1));
            repeat (12) @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: take the newest due record and check the load, then
    // check again just before the next tick, where frame_start must be low.
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   popped;
    bit   exp_rd;
    always @(negedge clk) begin
        popped = 1'b0;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            cur      = sb_q.pop_front();
            have_cur = 1'b1;
            popped   = 1'b1;
        end
        if (have_cur && (popped || cyc == cur.due + CLK_DIV - 1)) begin
            check("rgb", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'(cur.rgb));
            check("active", 32'(active_o), 32'(cur.act));
            check("hsync", 32'(hsync_o), 32'(cur.hs));
            check("vsync", 32'(vsync_o), 32'(cur.vs));
            check("frame_start", 32'(frame_start_o), 32'(popped ? cur.fs : 1'b0));
            if (cur.idle_bus) begin
                check("idle_fb_rd", 32'(fb_rd_o), 32'd0);
                check("idle_fb_addr", 32'(fb_addr_o), 32'd0);
            end
        end
        if (fb_rd_o || (fq.size() > 0 && fq[0].due <= cyc)) begin
            exp_rd = (fq.size() > 0 && fq[0].due == cyc);
            check("fb_rd", 32'(fb_rd_o), 32'(exp_rd));
            if (exp_rd) check("fb_addr", 32'(fb_addr_o), 32'(fq[0].addr));
            if (fq.size() > 0 && fq[0].due <= cyc) fq.delete(0);
        end
    end

    initial begin
        for (int i = 0; i < FB_WORDS; i++) mem[i] = PIX_W'($urandom);
        rst_ni       = 1'b0;
        en_scan_i    = 1'b0;
        border_rgb_i = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(idle_rec(cyc, 1'b1));
        rst_ni = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Two full frames plus a little: sync periods, border, clipping.
        scan(2 * FRAME_CLK + 600, 1'b0);

        // Drop en_scan mid-line, then restart from (0,0).
        border_rgb_i = PIX_W'($urandom);
        scan(CLK_DIV * (H_TOTAL * 10 + 23) + 2, 1'b0);

        // Random stretch ended by an asynchronous reset, then restart.
        border_rgb_i = PIX_W'($urandom);
        scan($urandom_range(3000, 5000), 1'b1);

        // Random cursor over a full frame.
        border_rgb_i = PIX_W'($urandom);
        cur_x_i   = 8'($urandom_range(0, FB_W - 1));
        cur_y_i   = 8'($urandom_range(0, FB_H - 1));
        cur_rgb_i = PIX_W'($urandom);
        cur_on_i  = 1'b1;
        scan(FRAME_CLK + 400, 1'b0);

        // Cursor at fb (5,3) in red, then turned off.
        cur_x_i   = 8'd5;
        cur_y_i   = 8'd3;
        cur_rgb_i = 12'hF00;
        scan(FRAME_CLK / 2, 1'b0);
        cur_on_i  = 1'b0;
        scan(FRAME_CLK / 2, 1'b1);

        rst_ni = 1'b1;
        en_scan_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        check("fetch_drain", 32'(fq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
